rom_rd_arbiter: RTL
===================

ROM_RD_ARBITER -- requirements
Module: rom_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, which is the byte-address width of both read ports.
REQ-002 SHALL have parameter ID_W, default 8, which is the AXI ID width.
REQ-003 SHALL have parameter ROM_AW, default 14, which is the ROM word-address width (ADDR_W-2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have ports s0_/s1_arvalid, input, 1 bit each: read-address valid per requester.
REQ-007 SHALL have ports s0_/s1_arready, output, 1 bit each: read-address ready.
REQ-008 SHALL have ports s0_/s1_araddr, input, ADDR_W bits each: byte start address; bits [1:0] are ignored.
REQ-009 SHALL have ports s0_/s1_arid, input, ID_W bits each: transaction ID.
REQ-010 SHALL have ports s0_/s1_arlen, input, 8 bits each: burst length minus 1; burst type is always INCR.
REQ-011 SHALL have ports s0_/s1_rvalid, output, 1 bit each, and s0_/s1_rready, input, 1 bit each: read-data handshake.
REQ-012 SHALL have ports s0_/s1_rdata, output, 32 bits each: read data.
REQ-013 SHALL have ports s0_/s1_rid, output, ID_W bits each, and s0_/s1_rlast, output, 1 bit each: response ID and last beat.
REQ-014 SHALL have ports s0_/s1_rresp, output, 2 bits each: always OKAY (2'b00).
REQ-015 SHALL have port rom_en, output, 1 bit: ROM read enable.
REQ-016 SHALL have port rom_addr, output, ROM_AW bits: ROM word address.
REQ-017 SHALL have port rom_dout, input, 32 bits: ROM data, valid exactly 1 cycle after the rom_en cycle.

Function
REQ-018 SHALL implement an FSM with two states: IDLE (no burst owned) and BURST (one requester owns the ROM).
REQ-019 In IDLE, SHALL assert arready only to the arbitration winner, combinationally from arvalid; arready is 0 for both ports in BURST.
REQ-020 Arbitration SHALL be round-robin: a 1-bit priority pointer selects the winner when both ports request; a lone requester always wins.
REQ-021 On each AR handshake, SHALL load the pointer with the non-winning port index.
REQ-022 On an AR handshake, SHALL latch owner, arid, araddr[ADDR_W-1:2] and arlen, clear the issue and return beat counters, and enter BURST next cycle.
REQ-023 In BURST, SHALL drive rom_en=1 while beats issued <= arlen and (FIFO occupancy + in-flight reads) < 2.
REQ-024 SHALL drive rom_addr as the latched word address plus the issue count, wrapping modulo 2^ROM_AW.
REQ-025 SHALL capture rom_dout into a 2-entry output FIFO one cycle after each rom_en, so the FIFO never overflows.
REQ-026 SHALL present the FIFO head only on the owner's R channel (rvalid=FIFO non-empty), with rid set to the latched ID and rlast=1 when the return count equals arlen.
REQ-027 The non-owner's rvalid SHALL be 0.
REQ-028 SHALL hold R-channel data and control stable while rvalid=1 and rready=0; throughput is 1 beat/cycle when rready stays high.
REQ-029 Latency SHALL be: AR handshake in cycle T, first rom_en in T+1, first rvalid in T+2.
REQ-030 On the rlast handshake, SHALL return to IDLE; the next AR handshake is possible in the following cycle.
REQ-031 SHALL keep rom_en=0 in IDLE and rom_addr at its last value.
REQ-032 An arvalid arriving mid-burst SHALL wait, unacknowledged, until IDLE.

Reset
REQ-033 While rst=0, SHALL drive the FSM to IDLE immediately: pointer=0, FIFO empty, counters 0, rom_en=0, rom_addr=0, all rvalid/rlast=0.
REQ-034 Reset mid-burst SHALL abandon the burst with no further beats; after release, arready reflects arvalid in the same cycle.

Verification
REQ-035 Single read: s0 araddr=0x0010, arlen=0, rready=1 -> rom_addr=4 at T+1; s0_rvalid, rlast=1, rid=arid at T+2; s1 silent.
REQ-036 Burst: s1 araddr=0x0100, arlen=3, rready=1 -> rom_addr 0x40..0x43 on consecutive cycles; 4 beats back-to-back; rlast only on the 4th.
REQ-037 Contention: both arvalid set from reset -> s0 granted first; then s1; then s0; strict alternation while both keep requesting.
REQ-038 Backpressure: arlen=7, rready toggles 1/0 -> no beat lost or duplicated, data in address order, rom_en never issued with occupancy+in-flight=2.
REQ-039 Wrap: araddr=0xFFFC, arlen=1 -> rom_addr 0x3FFF then 0x0000.
REQ-040 Reset mid-burst: rst=0 after beat 2 of an arlen=7 burst -> rvalid and rom_en go 0 without a clock edge; a new read then completes normally.

Source files
------------

// File: rtl/rom_rd_arbiter.sv
// Two-port AXI-style read arbiter in front of a single-cycle-latency ROM.
// Round-robin grants whole INCR bursts; a 2-entry skid FIFO absorbs R-channel backpressure.
module rom_rd_arbiter #(
  parameter int ADDR_W = 16,
  parameter int ID_W   = 8,
  parameter int ROM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [ID_W-1:0]   s0_arid,
  input  logic [7:0]        s0_arlen,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [31:0]       s0_rdata,
  output logic [ID_W-1:0]   s0_rid,
  output logic              s0_rlast,
  output logic [1:0]        s0_rresp,

  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [ID_W-1:0]   s1_arid,
  input  logic [7:0]        s1_arlen,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [31:0]       s1_rdata,
  output logic [ID_W-1:0]   s1_rid,
  output logic              s1_rlast,
  output logic [1:0]        s1_rresp,

  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_dout
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_ptr;
  logic                r_owner;
  logic [ROM_AW-1:0]   r_base;
  logic [ROM_AW-1:0]   r_addr_hold;
  logic [ID_W-1:0]     r_id;
  logic [7:0]          r_len;
  logic [8:0]          r_iss;
  logic [7:0]          r_ret;
  logic                r_vld_p1;
  logic [31:0]         r_fifo [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_occ;

  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_ar_hs;
  logic                w_win;
  logic [ADDR_W-1:0]   w_ar_addr;
  logic [ID_W-1:0]     w_ar_id;
  logic [7:0]          w_ar_len;
  logic                w_rvalid;
  logic                w_rready;
  logic                w_rhs;
  logic                w_last;
  logic                w_push;
  logic                w_pop;
  logic                w_rom_en;
  logic [ROM_AW-1:0]   w_rom_addr;
  logic [31:0]         w_head;
  logic                w_unused;

  assign w_unused = &{1'b0, s0_araddr[1:0], s1_araddr[1:0]};

  // Arbitration and FSM next state; arready is purely combinational in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    case (r_state)
      IDLE: begin
        if (s0_arvalid && (!s1_arvalid || !r_ptr)) begin
          w_gnt0 = 1'b1;
        end else if (s1_arvalid) begin
          w_gnt1 = 1'b1;
        end
        if (w_gnt0 || w_gnt1) begin
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (w_rhs && w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_ar_hs   = w_gnt0 | w_gnt1;
  assign w_win     = w_gnt1;
  assign w_ar_addr = w_win ? s1_araddr : s0_araddr;
  assign w_ar_id   = w_win ? s1_arid   : s0_arid;
  assign w_ar_len  = w_win ? s1_arlen  : s0_arlen;

  // Issue side: never let queued plus in-flight beats exceed the FIFO depth
  assign w_rom_en   = (r_state == BURST) && (r_iss <= {1'b0, r_len}) &&
                      ((3'(r_occ) + 3'(r_vld_p1)) < 3'd2);
  assign w_rom_addr = (r_state == BURST) ? (r_base + ROM_AW'(r_iss)) : r_addr_hold;

  // Return side: with an empty FIFO the in-flight ROM word is presented directly
  assign w_rvalid = (r_occ != 2'd0) || r_vld_p1;
  assign w_head   = (r_occ == 2'd0) ? rom_dout : r_fifo[r_rd_ptr];
  assign w_rready = r_owner ? s1_rready : s0_rready;
  assign w_rhs    = w_rvalid && w_rready;
  assign w_last   = (r_ret == r_len);
  assign w_pop    = w_rhs && (r_occ != 2'd0);
  assign w_push   = r_vld_p1 && !(w_rhs && (r_occ == 2'd0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_iss       <= '0;
      r_ret       <= '0;
      r_vld_p1    <= 1'b0;
      r_occ       <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_addr_hold <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_vld_p1 <= w_rom_en;
      if (w_ar_hs) begin
        r_ptr   <= ~w_win;
        r_owner <= w_win;
        r_iss   <= '0;
        r_ret   <= '0;
      end else begin
        if (w_rom_en) begin
          r_iss       <= r_iss + 9'd1;
          r_addr_hold <= w_rom_addr;
        end
        if (w_rhs) begin
          r_ret <= r_ret + 8'd1;
        end
      end
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
    end
  end

  // Burst descriptor and FIFO storage are only meaningful while BURST / occupied
  always_ff @(posedge clk) begin
    if (w_ar_hs) begin
      r_base <= ROM_AW'(w_ar_addr[ADDR_W-1:2]);
      r_id   <= w_ar_id;
      r_len  <= w_ar_len;
    end
    if (w_push) begin
      r_fifo[r_wr_ptr] <= rom_dout;
    end
  end

  assign rom_en     = w_rom_en;
  assign rom_addr   = w_rom_addr;

  assign s0_arready = w_gnt0;
  assign s1_arready = w_gnt1;

  assign s0_rvalid  = w_rvalid && !r_owner;
  assign s1_rvalid  = w_rvalid &&  r_owner;
  assign s0_rlast   = s0_rvalid && w_last;
  assign s1_rlast   = s1_rvalid && w_last;
  assign s0_rdata   = w_head;
  assign s1_rdata   = w_head;
  assign s0_rid     = r_id;
  assign s1_rid     = r_id;
  assign s0_rresp   = 2'b00;
  assign s1_rresp   = 2'b00;

endmodule
